sprite_collision_mixer: RTL and testbench

- Sits directly downstream of the sprite renderers: consumes each renderer's 1-bit gfx stream plus the playfield bit and produces the final registered RGB pixel by fixed priority.
- Accumulates sprite-sprite and sprite-playfield collisions over a frame.
- Snapshots the collision flags at the frame boundary and raises a one-cycle flag so game logic reads stable per-frame results.

---
 rtl/sprite_collision_mixer.sv | 153 +++++++++++++++
 tb/tb_sprite_collision_mixer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_collision_mixer.sv
// Final pixel priority mixer with per-frame sprite collision snapshots.
// Define SPRITE_HIT_CAPTURE_EN to add first sprite-sprite hit X/Y capture.
module sprite_collision_mixer #(
    parameter  int NSPRITES = 4,
    localparam int NPAIRS   = NSPRITES * (NSPRITES - 1) / 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    frame_end,
    input  logic                    display_on,
    input  logic [8:0]              hpos,
    input  logic [8:0]              vpos,
    input  logic [NSPRITES-1:0]     sprite_gfx,
    input  logic [3*NSPRITES-1:0]   sprite_color,
    input  logic                    playfield_gfx,
    input  logic [2:0]              playfield_color,
    input  logic [2:0]              bg_color,
    output logic [2:0]              rgb,
    output logic [NPAIRS-1:0]       ss_coll,
    output logic [NSPRITES-1:0]     sp_coll,
    output logic                    coll_valid,
    output logic [8:0]              hit_x,
    output logic [8:0]              hit_y
);

    logic [NPAIRS-1:0]   ss_hit;
    logic [NSPRITES-1:0] sp_hit;
    logic [NPAIRS-1:0]   ss_snap;
    logic [NSPRITES-1:0] sp_snap;

    logic [2:0]          rgb_q, rgb_d;
    logic [NPAIRS-1:0]   ss_acc_q, ss_acc_d;
    logic [NSPRITES-1:0] sp_acc_q, sp_acc_d;
    logic [NPAIRS-1:0]   ss_coll_q, ss_coll_d;
    logic [NSPRITES-1:0] sp_coll_q, sp_coll_d;
    logic                cv_q, cv_d;

    // Pair (i,j), i<j, numbered lexicographically
    for (genvar i = 0; i < NSPRITES; i++) begin : g_row
        for (genvar j = i + 1; j < NSPRITES; j++) begin : g_col
            localparam int K = i * NSPRITES - i * (i + 1) / 2 + j - i - 1;
            assign ss_hit[K] = display_on & sprite_gfx[i] & sprite_gfx[j];
        end
    end

    assign sp_hit  = display_on ? (sprite_gfx & {NSPRITES{playfield_gfx}})
                                : '0;
    assign ss_snap = ss_acc_q | ss_hit;
    assign sp_snap = sp_acc_q | sp_hit;

    always_comb begin
        logic [2:0] pix;
        pix = playfield_gfx ? playfield_color : bg_color;
        for (int i = NSPRITES - 1; i >= 0; i--) begin
            if (sprite_gfx[i]) pix = sprite_color[3*i +: 3];
        end
        rgb_d = display_on ? pix : 3'd0;
    end

    always_comb begin
        ss_acc_d  = frame_end ? '0 : ss_snap;
        sp_acc_d  = frame_end ? '0 : sp_snap;
        ss_coll_d = frame_end ? ss_snap : ss_coll_q;
        sp_coll_d = frame_end ? sp_snap : sp_coll_q;
        cv_d      = frame_end & ((|ss_snap) | (|sp_snap));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb_q     <= '0;
            ss_acc_q  <= '0;
            sp_acc_q  <= '0;
            ss_coll_q <= '0;
            sp_coll_q <= '0;
            cv_q      <= 1'b0;
        end else begin
            rgb_q     <= rgb_d;
            ss_acc_q  <= ss_acc_d;
            sp_acc_q  <= sp_acc_d;
            ss_coll_q <= ss_coll_d;
            sp_coll_q <= sp_coll_d;
            cv_q      <= cv_d;
        end
    end

    assign rgb        = rgb_q;
    assign ss_coll    = ss_coll_q;
    assign sp_coll    = sp_coll_q;
    assign coll_valid = cv_q;

`ifdef SPRITE_HIT_CAPTURE_EN
    typedef enum logic {IDLE, HELD} cap_state_t;

    cap_state_t state_q, state_d;
    logic [8:0] cap_x_q, cap_x_d;
    logic [8:0] cap_y_q, cap_y_d;
    logic [8:0] hit_x_q, hit_x_d;
    logic [8:0] hit_y_q, hit_y_d;
    logic       any_hit;

    assign any_hit = |ss_hit;

    always_comb begin
        state_d = state_q;
        cap_x_d = cap_x_q;
        cap_y_d = cap_y_q;
        hit_x_d = hit_x_q;
        hit_y_d = hit_y_q;
        if (frame_end) begin
            state_d = IDLE;
            case (state_q)
                HELD: begin
                    hit_x_d = cap_x_q;
                    hit_y_d = cap_y_q;
                end
                default: begin
                    hit_x_d = any_hit ? hpos : 9'd0;
                    hit_y_d = any_hit ? vpos : 9'd0;
                end
            endcase
        end else if (state_q == IDLE && any_hit) begin
            state_d = HELD;
            cap_x_d = hpos;
            cap_y_d = vpos;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cap_x_q <= '0;
            cap_y_q <= '0;
            hit_x_q <= '0;
            hit_y_q <= '0;
        end else begin
            state_q <= state_d;
            cap_x_q <= cap_x_d;
            cap_y_q <= cap_y_d;
            hit_x_q <= hit_x_d;
            hit_y_q <= hit_y_d;
        end
    end

    assign hit_x = hit_x_q;
    assign hit_y = hit_y_q;
`else
    logic unused_pos;
    assign unused_pos = ^{hpos, vpos};
    assign hit_x = '0;
    assign hit_y = '0;
`endif

endmodule

// File: tb/tb_sprite_collision_mixer.sv
// Directed bench for sprite_collision_mixer with a per-cycle reference model.
// Build with SPRITE_HIT_CAPTURE_EN to also check hit X/Y capture.
module tb_sprite_collision_mixer;

    localparam int N  = 4;
    localparam int NP = 6;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            frame_end = 1'b0;
    logic            display_on = 1'b0;
    logic [8:0]      hpos = '0;
    logic [8:0]      vpos = '0;
    logic [N-1:0]    gfx = '0;
    logic [3*N-1:0]  scol = '0;
    logic            pf = 1'b0;
    logic [2:0]      pfc = '0;
    logic [2:0]      bg = '0;
    logic [2:0]      rgb;
    logic [NP-1:0]   ss_coll;
    logic [N-1:0]    sp_coll;
    logic            coll_valid;
    logic [8:0]      hit_x;
    logic [8:0]      hit_y;

    int checks = 0;
    int errors = 0;

    sprite_collision_mixer #(.NSPRITES(N)) dut (
        .clk(clk), .reset(reset), .frame_end(frame_end),
        .display_on(display_on), .hpos(hpos), .vpos(vpos),
        .sprite_gfx(gfx), .sprite_color(scol),
        .playfield_gfx(pf), .playfield_color(pfc), .bg_color(bg),
        .rgb(rgb), .ss_coll(ss_coll), .sp_coll(sp_coll),
        .coll_valid(coll_valid), .hit_x(hit_x), .hit_y(hit_y)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

`ifdef SPRITE_HIT_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    // Reference model: pair occupancy kept as a 2-D matrix of sprite pairs
    bit          acc_ss [N][N];
    bit          acc_sp [N];
    logic [2:0]  m_rgb;
    logic [NP-1:0] m_ss;
    logic [N-1:0]  m_sp;
    logic        m_cv;
    bit          m_seen;
    logic [8:0]  m_cx, m_cy, m_hx, m_hy;

    function automatic int pidx(int a, int b);
        int n;
        n = 0;
        for (int i = 0; i < N; i++)
            for (int j = i + 1; j < N; j++) begin
                if (i == a && j == b) return n;
                n++;
            end
        return -1;
    endfunction

    always @(posedge clk or negedge reset) begin
        logic [2:0] c;
        bit h;
        bit any;
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                acc_sp[i] = 0;
                for (int j = 0; j < N; j++) acc_ss[i][j] = 0;
            end
            m_rgb = 0; m_ss = 0; m_sp = 0; m_cv = 0;
            m_seen = 0; m_cx = 0; m_cy = 0; m_hx = 0; m_hy = 0;
        end else begin
            c = bg;
            if (pf) c = pfc;
            for (int i = N - 1; i >= 0; i--)
                if (gfx[i]) c = scol[3*i +: 3];
            m_rgb = display_on ? c : 3'd0;
            any = 0;
            if (frame_end) begin
                m_ss = 0; m_sp = 0;
            end
            for (int i = 0; i < N; i++) begin
                h = display_on && gfx[i] && pf;
                if (frame_end) begin
                    if (acc_sp[i] || h) m_sp[i] = 1'b1;
                    acc_sp[i] = 0;
                end else if (h) acc_sp[i] = 1;
                for (int j = i + 1; j < N; j++) begin
                    h = display_on && gfx[i] && gfx[j];
                    any = any || h;
                    if (frame_end) begin
                        if (acc_ss[i][j] || h) m_ss[pidx(i, j)] = 1'b1;
                        acc_ss[i][j] = 0;
                    end else if (h) acc_ss[i][j] = 1;
                end
            end
            if (frame_end) begin
                m_cv = (m_ss != 0) || (m_sp != 0);
                if (m_seen) begin m_hx = m_cx; m_hy = m_cy; end
                else if (any) begin m_hx = hpos; m_hy = vpos; end
                else begin m_hx = 0; m_hy = 0; end
                m_seen = 0;
            end else begin
                m_cv = 0;
                if (!m_seen && any) begin
                    m_seen = 1; m_cx = hpos; m_cy = vpos;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("rgb", 32'(rgb), 32'(m_rgb));
            chk("ss_coll", 32'(ss_coll), 32'(m_ss));
            chk("sp_coll", 32'(sp_coll), 32'(m_sp));
            chk("coll_valid", 32'(coll_valid), 32'(m_cv));
            chk("hit_x", 32'(hit_x), CAP ? 32'(m_hx) : 32'd0);
            chk("hit_y", 32'(hit_y), CAP ? 32'(m_hy) : 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_rgb"}, 32'(rgb), 32'd0);
        chk({tag, "_ss"}, 32'(ss_coll), 32'd0);
        chk({tag, "_sp"}, 32'(sp_coll), 32'd0);
        chk({tag, "_cv"}, 32'(coll_valid), 32'd0);
        chk({tag, "_hx"}, 32'(hit_x), 32'd0);
        chk({tag, "_hy"}, 32'(hit_y), 32'd0);
    endtask

    int cv_cnt;

    initial begin
        #1 reset = 1'b0;
        #1 chk_zero("por");
        #20 reset = 1'b1;
        step();

        // Priority: sprite 1 beats sprite 2 and playfield
        scol = {3'b000, 3'b100, 3'b010, 3'b000};
        pfc = 3'b111; bg = 3'b001;
        display_on = 1'b1; gfx = 4'b0110; pf = 1'b1;
        step();
        chk("prio_s1", 32'(rgb), 32'b010);
        gfx = 4'b0000; pf = 1'b0;
        step();
        chk("prio_bg", 32'(rgb), 32'b001);
        display_on = 1'b0;
        step();
        chk("blank", 32'(rgb), 32'd0);
        frame();
        chk("f0_ss", 32'(ss_coll), 32'b001000);
        chk("f0_sp", 32'(sp_coll), 32'b0110);
        chk("f0_cv", 32'(coll_valid), 32'd1);
        step();
        chk("f0_cv_drop", 32'(coll_valid), 32'd0);

        // Asynchronous reset mid-frame with accumulators set
        display_on = 1'b1; gfx = 4'b0011; hpos = 9'd5; vpos = 9'd6;
        step();
        reset = 1'b0;
        #1 chk_zero("areset");
        #3 reset = 1'b1;
        gfx = 4'b0000;
        step();
        frame();
        chk("post_rst_ss", 32'(ss_coll), 32'd0);
        chk("post_rst_sp", 32'(sp_coll), 32'd0);
        chk("post_rst_cv", 32'(coll_valid), 32'd0);
        step();

        // Sprites 1 and 3 overlap, first at (40,100)
        gfx = 4'b1010; vpos = 9'd100;
        for (int x = 40; x < 43; x++) begin
            hpos = 9'(x);
            step();
        end
        gfx = 4'b0000; hpos = 9'd43;
        step();
        frame();
        cv_cnt = coll_valid ? 1 : 0;
        chk("s3_ss", 32'(ss_coll), 32'b010000);
        chk("s3_sp", 32'(sp_coll), 32'd0);
        chk("s3_hx", 32'(hit_x), CAP ? 32'd40 : 32'd0);
        chk("s3_hy", 32'(hit_y), CAP ? 32'd100 : 32'd0);
        repeat (3) begin
            step();
            if (coll_valid) cv_cnt++;
        end
        chk("s3_cv_pulses", 32'(cv_cnt), 32'd1);

        // Sprite 2 hits playfield only on the frame_end cycle
        gfx = 4'b0100; pf = 1'b1;
        frame();
        chk("s4_sp", 32'(sp_coll), 32'b0100);
        chk("s4_ss", 32'(ss_coll), 32'd0);
        chk("s4_hx", 32'(hit_x), 32'd0);
        gfx = 4'b0000; pf = 1'b0;
        repeat (4) step();
        frame();
        chk("s4b_sp", 32'(sp_coll), 32'd0);
        chk("s4b_cv", 32'(coll_valid), 32'd0);
        chk("s4b_hx", 32'(hit_x), 32'd0);
        chk("s4b_hy", 32'(hit_y), 32'd0);

        // Overlap during blanking is ignored
        display_on = 1'b0; gfx = 4'b1111; pf = 1'b1;
        repeat (3) step();
        frame();
        chk("s5_ss", 32'(ss_coll), 32'd0);
        chk("s5_sp", 32'(sp_coll), 32'd0);
        chk("s5_cv", 32'(coll_valid), 32'd0);

        // Same-cycle sprite hit on frame_end while idle
        display_on = 1'b1; pf = 1'b0; gfx = 4'b0101;
        hpos = 9'd7; vpos = 9'd9;
        frame();
        chk("s6_ss", 32'(ss_coll), 32'b000010);
        chk("s6_hx", 32'(hit_x), CAP ? 32'd7 : 32'd0);
        chk("s6_hy", 32'(hit_y), CAP ? 32'd9 : 32'd0);

        // Back-to-back frame_end pulses
        gfx = 4'b0011; hpos = 9'd20;
        step();
        frame();
        gfx = 4'b1100;
        frame();
        chk("b2b_ss", 32'(ss_coll), 32'b100000);
        gfx = 4'b0000;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
